// File: rtl/led_matrix_scan.sv
// Row-scanned LED matrix driver: framebuffer, per-row shadow latch and PWM brightness.
// Row lines are one-hot active-high, column lines active-low, and every output is registered.
module led_matrix_scan #(
    parameter int ROWS         = 6,
    parameter int COLS         = 6,
    parameter int BPP          = 2,
    parameter int SLOT_CYCLES  = 4,
    parameter int BLANK_CYCLES = 2,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [CW-1:0]   wr_col,
    input  logic [BPP-1:0]  wr_data,
    output logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic            frame_start
);

    localparam int LEVELS = (1 << BPP) - 1;
    localparam int MAXC   = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
    localparam int CNTW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} stateT;

    stateT           state, stateNext;
    logic [RW-1:0]   rIdx, rNext;
    logic [BPP-1:0]  slot, slotNext;
    logic [CNTW-1:0] cnt, cntNext;
    logic            loadShadow;
    logic [ROWS-1:0] rowNext;
    logic [COLS-1:0] colNext;
    logic            frameNext;

    logic [BPP-1:0] fb [ROWS][COLS];
    logic [BPP-1:0] shadow [COLS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb <= '{default: '0};
        end else if (wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS)) begin
            fb[wr_row][wr_col] <= wr_data;
        end
    end

    // Shadow samples fb before any same-edge write lands, so that write waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '{default: '0};
        end else if (loadShadow) begin
            shadow <= fb[rNext];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rIdx        <= '0;
            slot        <= '0;
            cnt         <= '0;
            row         <= '0;
            col         <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= stateNext;
            rIdx        <= rNext;
            slot        <= slotNext;
            cnt         <= cntNext;
            row         <= rowNext;
            col         <= colNext;
            frame_start <= frameNext;
        end
    end

    always_comb begin
        stateNext  = state;
        rNext      = rIdx;
        slotNext   = slot;
        cntNext    = cnt;
        loadShadow = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    stateNext  = BLANK;
                    rNext      = '0;
                    cntNext    = '0;
                    loadShadow = 1'b1;
                end
            end
            BLANK: begin
                if (cnt == CNTW'(BLANK_CYCLES - 1)) begin
                    stateNext = DRIVE;
                    slotNext  = '0;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            DRIVE: begin
                if (cnt == CNTW'(SLOT_CYCLES - 1)) begin
                    cntNext = '0;
                    if (slot == BPP'(LEVELS - 1)) begin
                        stateNext  = BLANK;
                        rNext      = (rIdx == RW'(ROWS - 1)) ? '0 : rIdx + 1'b1;
                        loadShadow = 1'b1;
                    end else begin
                        slotNext = slot + 1'b1;
                    end
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (!enable) begin
            stateNext  = IDLE;
            rNext      = '0;
            slotNext   = '0;
            cntNext    = '0;
            loadShadow = 1'b0;
        end

        // Outputs are decoded from the next state so that pins and state update on one edge.
        rowNext   = '0;
        colNext   = '1;
        frameNext = loadShadow && (rNext == '0);
        if (stateNext == DRIVE) begin
            rowNext = ROWS'(1) << rNext;
            for (int unsigned c = 0; c < COLS; c++) begin
                colNext[c] = ~(shadow[c] > slotNext);
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: a timeline model predicts row/col/frame_start every cycle,
// and directed literal checks pin the scan order, the PWM levels and the reset/enable behaviour.
module tb_led_matrix_scan;

    localparam int ROWS   = 6;
    localparam int COLS   = 6;
    localparam int BLANKC = 2;
    localparam int SLOTC  = 4;
    localparam int TROW   = 14;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [1:0] wr_data;
    logic [5:0] row;
    logic [5:0] col;
    logic       frame_start;

    int nCmp = 0;
    int nBad = 0;

    led_matrix_scan #(
        .ROWS(6), .COLS(6), .BPP(2), .SLOT_CYCLES(4), .BLANK_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .row(row), .col(col), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: t counts cycles since the scan started; row and slot follow by division.
    int         mfb [ROWS][COLS];
    int         msh [COLS];
    bit         running = 1'b0;
    int         t = 0;
    int         ph, rr, sl;
    logic [5:0] eRow = '0;
    logic [5:0] eCol = '1;
    logic       eFs = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) mfb[i][j] = 0;
            for (int j = 0; j < COLS; j++) msh[j] = 0;
            running = 1'b0;
            t = 0;
            eRow = '0;
            eCol = '1;
            eFs = 1'b0;
        end else begin
            if (!enable) begin
                running = 1'b0;
                eRow = '0;
                eCol = '1;
                eFs = 1'b0;
            end else begin
                if (!running) begin
                    running = 1'b1;
                    t = 0;
                end else begin
                    t++;
                end
                ph = t % TROW;
                rr = (t / TROW) % ROWS;
                if (ph == 0)
                    for (int j = 0; j < COLS; j++) msh[j] = mfb[rr][j];
                eRow = '0;
                eCol = '1;
                eFs = (ph == 0) && (rr == 0);
                if (ph >= BLANKC) begin
                    sl = (ph - BLANKC) / SLOTC;
                    eRow[rr] = 1'b1;
                    for (int j = 0; j < COLS; j++)
                        if (msh[j] > sl) eCol[j] = 1'b0;
                end
            end
            if (wr_en && wr_row < ROWS && wr_col < COLS) mfb[wr_row][wr_col] = int'(wr_data);
        end
    end

    always @(negedge clk) begin
        check("model_row", {26'b0, row}, {26'b0, eRow});
        check("model_col", {26'b0, col}, {26'b0, eCol});
        check("model_fs", {31'b0, frame_start}, {31'b0, eFs});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vals [6] = '{0, 1, 2, 3, 3, 0};
        rst_n = 1'b0; enable = 1'b1; wr_en = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        cyc(3);
        check("rst_row", {26'b0, row}, 32'h0);
        check("rst_col", {26'b0, col}, 32'h3F);
        check("rst_fs", {31'b0, frame_start}, 32'h0);
        rst_n = 1'b1;

        cyc(1);
        check("t0_fs", {31'b0, frame_start}, 32'h1);
        check("t0_row", {26'b0, row}, 32'h0);
        cyc(1);
        check("t1_fs", {31'b0, frame_start}, 32'h0);
        cyc(1);
        check("t2_row", {26'b0, row}, 32'h01);
        check("t2_col", {26'b0, col}, 32'h3F);
        cyc(12);
        check("t14_row", {26'b0, row}, 32'h0);
        cyc(2);
        check("t16_row", {26'b0, row}, 32'h02);
        cyc(68);
        check("t84_fs", {31'b0, frame_start}, 32'h1);

        for (int c = 0; c < 6; c++) begin
            wr_en = 1'b1; wr_row = 3'd2; wr_col = 3'(c); wr_data = 2'(vals[c]);
            cyc(1);
        end
        wr_en = 1'b0;
        cyc(24);
        check("pwm_row", {26'b0, row}, 32'h04);
        check("pwm_s0", {26'b0, col}, {26'b0, 6'b100001});
        cyc(4);
        check("pwm_s1", {26'b0, col}, {26'b0, 6'b100011});
        cyc(4);
        check("pwm_s2", {26'b0, col}, {26'b0, 6'b100111});

        cyc(63);
        wr_en = 1'b1; wr_row = 3'd1; wr_col = 3'd0; wr_data = 2'd3;
        cyc(1);
        wr_en = 1'b0;
        cyc(4);
        check("tear_row", {26'b0, row}, 32'h02);
        check("tear_same_pass", {26'b0, col}, 32'h3F);
        cyc(78);
        check("tear_next_row", {26'b0, row}, 32'h02);
        check("tear_next_first", {26'b0, col}, {26'b0, 6'b111110});
        cyc(11);
        check("tear_next_last", {26'b0, col}, {26'b0, 6'b111110});

        wr_en = 1'b1; wr_row = 3'd6; wr_col = 3'd0; wr_data = 2'd3;
        cyc(1);
        wr_row = 3'd0; wr_col = 3'd7;
        cyc(1);
        wr_en = 1'b0;
        cyc(59);
        check("oor_row", {26'b0, row}, 32'h01);
        check("oor_col", {26'b0, col}, 32'h3F);

        cyc(43);
        check("drop_pre_row", {26'b0, row}, 32'h08);
        enable = 1'b0;
        cyc(1);
        check("drop_row", {26'b0, row}, 32'h0);
        check("drop_col", {26'b0, col}, 32'h3F);
        check("drop_fs", {31'b0, frame_start}, 32'h0);
        cyc(3);
        enable = 1'b1;
        cyc(1);
        check("reen_fs", {31'b0, frame_start}, 32'h1);
        check("reen_row", {26'b0, row}, 32'h0);
        cyc(2);
        check("reen_row0", {26'b0, row}, 32'h01);
        cyc(28);
        check("pre_rst_col", {26'b0, col}, {26'b0, 6'b100001});

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_row", {26'b0, row}, 32'h0);
        check("arst_col", {26'b0, col}, 32'h3F);
        check("arst_fs", {31'b0, frame_start}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1);
        check("post_rst_fs", {31'b0, frame_start}, 32'h1);
        cyc(30);
        check("post_rst_row", {26'b0, row}, 32'h04);
        check("post_rst_col", {26'b0, col}, 32'h3F);
        cyc(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
